demux_1to2_stream: RTL

//   Registered 1-to-2 stream demultiplexer: the inverse of the 2-to-1 operand mux.
//   One input word D is steered to output channel A (S=0) or B (S=1).

---
 rtl/demux_1to2_stream.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream: steers one input word stream into two independently buffered output channels (A, B).
// Latency: one cycle from an accepted push to the head of an empty channel FIFO.
// Backpressure: in_ready is the registered not-full flag of the selected channel only; a stalled channel never blocks the other.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   D, S, in_valid      input word, route select (0 -> A, 1 -> B), valid
//   in_ready            selected channel FIFO can accept this cycle
//   A, A_valid, A_ready channel A head word and handshake
//   B, B_valid, B_ready channel B head word and handshake
//   A_count, B_count    per-channel delivered-word counters (only when DEMUX_CNT_EN is defined)
//
// Build option: define DEMUX_CNT_EN to add the A_count/B_count ports and counters.

// Per-channel FIFO with wrap-bit pointers. When empty, the head shows the last
// popped word (zero after reset) rather than stale storage.
module demux_1to2_stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             vld,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // Equal index with differing wrap bit means the writer has lapped the reader.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign vld     = !empty;
    assign head    = empty ? last : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                last   <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr[AW-1:0]] <= wdat;
        end
    end
endmodule

module demux_1to2_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             S,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A,
    output logic             A_valid,
    input  logic             A_ready,
    output logic [WIDTH-1:0] B,
    output logic             B_valid,
    input  logic             B_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [31:0]      A_count,
    output logic [31:0]      B_count
`endif
);
    logic a_full;
    logic b_full;
    logic push_a;
    logic push_b;

    // Only registered full flags feed in_ready, so a consumer's ready never
    // reaches the producer combinationally; a pop on a full FIFO frees the
    // slot for the following cycle.
    assign in_ready = S ? !b_full : !a_full;
    assign push_a   = in_valid && in_ready && !S;
    assign push_b   = in_valid && in_ready && S;

    demux_1to2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk  (clk),
        .rst  (rst),
        .push (push_a),
        .wdat (D),
        .pop  (A_ready),
        .head (A),
        .vld  (A_valid),
        .full (a_full)
    );

    demux_1to2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk  (clk),
        .rst  (rst),
        .push (push_b),
        .wdat (D),
        .pop  (B_ready),
        .head (B),
        .vld  (B_valid),
        .full (b_full)
    );

`ifdef DEMUX_CNT_EN
    // Delivered-word counters; wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            A_count <= '0;
            B_count <= '0;
        end else begin
            if (A_valid && A_ready) begin
                A_count <= A_count + 32'd1;
            end
            if (B_valid && B_ready) begin
                B_count <= B_count + 32'd1;
            end
        end
    end
`endif
endmodule
